tp_dis_loader: RTL and testbench

Streaming loader for the two-point distance table. It accepts packed 64-bit words from the host-side bus path, unpacks them into individual distances and generates the triangular addresses. It drives the `tp_dis_write` / `tp_dis_waddr` / `tp_dis_wdata` broadcast that every replica node consumes, so software can stream the table without computing per-entry addresses.

---
 rtl/tp_dis_loader.sv | 203 ++++++++++++++++++++
 tb/tb_tp_dis_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_dis_loader.sv
// tp_dis_loader: streams packed 64-bit words of the two-point distance table
// into the replica-node write broadcast, generating triangular addresses
// (j-major, address = j(j-1)/2 + i) so software never computes them.
//
// Handshake: a word on s_data is transferred in any cycle where
// s_valid && s_ready are both high at the rising edge of clk. s_ready is
// combinational from stall and never depends on s_valid; the source may hold
// s_valid high for as long as it likes and must keep s_data stable until the
// transfer happens.
module tp_dis_loader #(
  parameter int CITY_NUM_LOG = 7,
  parameter int DATA_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CITY_NUM_LOG:0]     city_num,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [63:0]               s_data,
  input  logic                      stall,
  output logic                      tp_dis_write,
  output logic [2*CITY_NUM_LOG-2:0] tp_dis_waddr,
  output logic [DATA_W-1:0]         tp_dis_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                dbg_state,
  output logic [CITY_NUM_LOG:0]     dbg_i,
  output logic [CITY_NUM_LOG:0]     dbg_j
);

  localparam int AW      = 2*CITY_NUM_LOG-1;   // address width
  localparam int CW      = 2*CITY_NUM_LOG;     // entry / word counter width
  localparam int JW      = CITY_NUM_LOG+1;     // i/j counter width (j reaches N)
  localparam int LANES   = 64/DATA_W;
  localparam int LANE_SH = $clog2(LANES);
  localparam int LANE_W  = (LANE_SH > 0) ? LANE_SH : 1;

  localparam logic [JW-1:0]     N_MAX     = {1'b1, {CITY_NUM_LOG{1'b0}}};
  localparam logic [JW-1:0]     N_MIN     = JW'(2);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;

  // load geometry, captured on a legal start
  logic [CW-1:0]       words_total_q;
  logic [CW-1:0]       words_taken_q;
  logic [CW-1:0]       remain_q;

  // address generation
  logic [AW-1:0]       addr_q;
  logic [JW-1:0]       i_q;
  logic [JW-1:0]       j_q;

  // one-word holding register and the lane being written from it
  logic                hold_valid_q;
  logic [63:0]         hold_data_q;
  logic [LANE_W-1:0]   lane_q;

  logic                err_q;

  // combinational helpers
  logic [CW-1:0]       prod;
  logic [CW-1:0]       p_calc;
  logic [CW-1:0]       w_calc;
  logic                n_ok;
  logic                start_legal;
  logic                start_reject;
  logic                last_lane;
  logic                issue;
  logic                accept;

  // P = N(N-1)/2 and W = ceil(P/LANES); only meaningful for legal N
  assign prod   = CW'(city_num) * CW'(city_num - JW'(1));
  assign p_calc = prod >> 1;
  assign w_calc = (p_calc + CW'(LANES-1)) >> LANE_SH;

  // a start is only honoured from IDLE with 2 <= N <= 2^CITY_NUM_LOG;
  // anything else (bad N, or start during LOAD/FIN) only raises err
  assign n_ok         = (city_num >= N_MIN) && (city_num <= N_MAX);
  assign start_legal  = start && (state_q == S_IDLE) && n_ok;
  assign start_reject = start && !start_legal;

  // the holding register frees after its last lane or after the final entry
  assign last_lane = (lane_q == LAST_LANE) || (remain_q == CW'(1));
  assign accept    = s_valid && s_ready;

  // next-state and handshake/strobe decode
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    s_ready      = 1'b0;
    issue        = 1'b0;
    tp_dis_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_legal) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy         = 1'b1;
        issue        = hold_valid_q && !stall;
        tp_dis_write = issue;
        s_ready      = (words_taken_q < words_total_q) &&
                       (!hold_valid_q || (last_lane && !stall));
        if (issue && (remain_q == CW'(1))) state_d = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // sticky error flag: set by any rejected start, cleared by a legal one
  always_ff @(posedge clk) begin
    if (reset)             err_q <= 1'b0;
    else if (start_legal)  err_q <= 1'b0;
    else if (start_reject) err_q <= 1'b1;
  end

  // load geometry and word accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      words_total_q <= '0;
      words_taken_q <= '0;
    end else if (start_legal) begin
      words_total_q <= w_calc;
      words_taken_q <= '0;
    end else if (accept) begin
      words_taken_q <= words_taken_q + CW'(1);
    end
  end

  // holding register: load on transfer, step lanes on each issued write
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      lane_q       <= '0;
    end else if (start_legal) begin
      hold_valid_q <= 1'b0;
      lane_q       <= '0;
    end else if (accept) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= s_data;
      lane_q       <= '0;
    end else if (issue) begin
      if (last_lane) begin
        hold_valid_q <= 1'b0;
        lane_q       <= '0;
      end else begin
        lane_q <= lane_q + LANE_W'(1);
      end
    end
  end

  // address, (i, j) and remaining-entry counters advance once per issued write
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      remain_q <= '0;
    end else if (start_legal) begin
      addr_q   <= '0;
      i_q      <= '0;
      j_q      <= JW'(1);
      remain_q <= p_calc;
    end else if (issue) begin
      addr_q   <= addr_q + AW'(1);
      remain_q <= remain_q - CW'(1);
      if ((i_q + JW'(1)) == j_q) begin
        i_q <= '0;
        j_q <= j_q + JW'(1);
      end else begin
        i_q <= i_q + JW'(1);
      end
    end
  end

  assign tp_dis_waddr = addr_q;
  assign tp_dis_wdata = hold_data_q[DATA_W*int'(lane_q) +: DATA_W];
  assign err          = err_q;
  assign dbg_state    = state_q;
  assign dbg_i        = i_q;
  assign dbg_j        = j_q;

endmodule

// File: tb/tb_tp_dis_loader.sv
// Testbench for tp_dis_loader: table of load configurations plus directed
// multi-cycle sequences, all writes checked against a queue of expected
// {address, data} entries built from the j-major pair order.
module tb_tp_dis_loader;

  localparam int CNL   = 7;
  localparam int DW    = 16;
  localparam int AW    = 2*CNL-1;
  localparam int LANES = 64/DW;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           start;
  logic [CNL:0]   city_num;
  logic           s_valid;
  logic           s_ready;
  logic [63:0]    s_data;
  logic           stall;
  logic           tp_dis_write;
  logic [AW-1:0]  tp_dis_waddr;
  logic [DW-1:0]  tp_dis_wdata;
  logic           busy;
  logic           done;
  logic           err;
  logic [1:0]     dbg_state;
  logic [CNL:0]   dbg_i;
  logic [CNL:0]   dbg_j;

  tp_dis_loader #(.CITY_NUM_LOG(CNL), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .city_num     (city_num),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .stall        (stall),
    .tp_dis_write (tp_dis_write),
    .tp_dis_waddr (tp_dis_waddr),
    .tp_dis_wdata (tp_dis_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .dbg_state    (dbg_state),
    .dbg_i        (dbg_i),
    .dbg_j        (dbg_j)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [63:0]      words[$];
  logic [AW+DW-1:0] exp_q[$];

  typedef struct {
    int n;
    int stall_pct;
    int valid_pct;
    bit exp_err;
    int exp_writes;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: random packed words, enough for every pair plus one spare
  function automatic void gen_words(input int n);
    int p;
    p = (n * (n - 1)) / 2;
    words.delete();
    for (int w = 0; w < (p + LANES - 1) / LANES + 1; w++)
      words.push_back({$urandom, $urandom});
  endfunction

  // reference model: entry k of the stream is lane k%LANES of word k/LANES,
  // and it belongs to pair (i, j) visited in j-major order
  function automatic void build_exp(input int n);
    int k;
    logic [63:0] wd;
    k = 0;
    exp_q.delete();
    for (int j = 1; j < n; j++) begin
      for (int i = 0; i < j; i++) begin
        wd = words[k / LANES];
        exp_q.push_back({AW'((j * (j - 1)) / 2 + i), wd[(k % LANES) * DW +: DW]});
        k++;
      end
    end
  endfunction

  // driver: tasks are entered and left 1 time unit after a rising edge
  task automatic do_start(input int n, input bit exp_err);
    start    = 1'b1;
    city_num = (CNL+1)'(n);
    s_valid  = 1'b0;
    stall    = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_after_start", err, exp_err);
    chk("busy_after_start", busy, !exp_err);
    @(posedge clk); #1;
  endtask

  task automatic idle_probe();
    s_valid = 1'b1;
    s_data  = {$urandom, $urandom};
    repeat (4) begin
      @(negedge clk);
      chk("ready_when_idle", s_ready, 1'b0);
      chk("no_write_when_idle", tp_dis_write, 1'b0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic stream(input int stall_pct, input int valid_pct, input int abort_wr,
                        input int stall_at_addr, input int inj_start_cyc, input bit inj_fin,
                        output int wr_o, output int sent_o, output bit done_o, output int gaps_o);
    int sent, wr, stall_left, last_wr_cyc, gaps;
    bit acc, fin_next, forced, dn;
    logic [AW+DW-1:0] e;
    sent = 0; wr = 0; stall_left = 0; last_wr_cyc = -10; gaps = 0;
    fin_next = 1'b0; dn = 1'b0;
    for (int cyc = 0; cyc < 40000 && !dn; cyc++) begin
      s_valid  = (sent < words.size()) && ($urandom_range(0, 99) < valid_pct);
      s_data   = (sent < words.size()) ? words[sent] : '0;
      forced   = (stall_left > 0);
      stall    = forced || ($urandom_range(0, 99) < stall_pct);
      if (stall_left > 0) stall_left--;
      start    = (cyc == inj_start_cyc) || fin_next;
      city_num = (CNL+1)'(3);
      fin_next = 1'b0;
      @(negedge clk);
      if (stall) chk("write_during_stall", tp_dis_write, 1'b0);
      if (forced && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("waddr_held_in_stall", tp_dis_waddr, e[AW+DW-1:DW]);
        chk("wdata_held_in_stall", tp_dis_wdata, e[DW-1:0]);
      end
      if (tp_dis_write) begin
        chk("busy_while_writing", busy, 1'b1);
        if (exp_q.size() == 0) begin
          chk("write_beyond_table", tp_dis_write, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", tp_dis_waddr, e[AW+DW-1:DW]);
          chk("wdata", tp_dis_wdata, e[DW-1:0]);
          if (inj_fin && exp_q.size() == 0) fin_next = 1'b1;
        end
        if (int'(tp_dis_waddr) == stall_at_addr) stall_left = 3;
        wr++;
        last_wr_cyc = cyc;
      end else if (wr > 0 && exp_q.size() > 0) begin
        gaps++;
      end
      if (done) begin
        dn = 1'b1;
        chk("done_one_after_last", cyc - last_wr_cyc, 1);
        chk("busy_low_at_done", busy, 1'b0);
        chk("ready_low_at_done", s_ready, 1'b0);
        chk("all_entries_at_done", exp_q.size(), 0);
      end
      acc = s_valid && s_ready;
      if (acc) chk("word_within_count", sent < words.size() - 1, 1'b1);
      @(posedge clk); #1;
      if (acc) sent++;
      if (abort_wr > 0 && wr >= abort_wr) break;
    end
    start = 1'b0; s_valid = 1'b0; stall = 1'b0;
    wr_o = wr; sent_o = sent; done_o = dn; gaps_o = gaps;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    chk({tag, "_write"}, tp_dis_write, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_waddr"}, tp_dis_waddr, '0);
    chk({tag, "_wdata"}, tp_dis_wdata, '0);
    @(posedge clk); #1;
  endtask

  // watchdog
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr, sent, gaps;
    bit dn;

    vecs[0] = '{1,   0,  100, 1'b1, 0};
    vecs[1] = '{2,   20, 70,  1'b0, 1};
    vecs[2] = '{129, 0,  100, 1'b1, 0};
    vecs[3] = '{3,   0,  100, 1'b0, 3};
    vecs[4] = '{0,   0,  100, 1'b1, 0};
    vecs[5] = '{5,   30, 80,  1'b0, 10};
    vecs[6] = '{7,   10, 90,  1'b0, 21};
    vecs[7] = '{10,  25, 60,  1'b0, 45};
    vecs[8] = '{16,  40, 50,  1'b0, 120};
    vecs[9] = '{128, 0,  100, 1'b0, 8128};

    reset = 1'b1; start = 1'b0; city_num = '0;
    s_valid = 1'b0; s_data = '0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("reset");

    // directed N=4 load with known data 1..6 and a spare third word
    gen_words(4);
    words[0] = 64'h0004_0003_0002_0001;
    words[1] = 64'hFFFF_FFFF_0006_0005;
    build_exp(4);
    do_start(4, 1'b0);
    stream(0, 100, -1, -1, -1, 1'b0, wr, sent, dn, gaps);
    chk("n4_writes", wr, 6);
    chk("n4_words", sent, 2);
    chk("n4_done", dn, 1'b1);
    chk("n4_gaps", gaps, 0);

    // table of configurations, randomized data / valid / stall
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].exp_err) begin
        do_start(vecs[v].n, 1'b1);
        idle_probe();
      end else begin
        gen_words(vecs[v].n);
        build_exp(vecs[v].n);
        do_start(vecs[v].n, 1'b0);
        stream(vecs[v].stall_pct, vecs[v].valid_pct, -1, -1, -1, 1'b0, wr, sent, dn, gaps);
        chk("tbl_writes", wr, vecs[v].exp_writes);
        chk("tbl_words", sent, words.size() - 1);
        chk("tbl_done", dn, 1'b1);
        if (vecs[v].stall_pct == 0 && vecs[v].valid_pct == 100) chk("tbl_gaps", gaps, 0);
      end
    end

    // N=5 with stall held for three cycles after the write to address 2
    gen_words(5);
    build_exp(5);
    do_start(5, 1'b0);
    stream(0, 100, -1, 2, -1, 1'b0, wr, sent, dn, gaps);
    chk("stall_writes", wr, 10);
    chk("stall_done", dn, 1'b1);

    // N=6 aborted by reset after the third write, then a clean N=3 load
    gen_words(6);
    build_exp(6);
    do_start(6, 1'b0);
    stream(0, 100, 3, -1, -1, 1'b0, wr, sent, dn, gaps);
    chk("abort_writes", wr, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_state("midload_reset");
    gen_words(3);
    build_exp(3);
    do_start(3, 1'b0);
    stream(0, 100, -1, -1, -1, 1'b0, wr, sent, dn, gaps);
    chk("after_reset_writes", wr, 3);
    chk("after_reset_done", dn, 1'b1);

    // start pulsed while an N=4 load is running: rejected, load completes
    gen_words(4);
    build_exp(4);
    do_start(4, 1'b0);
    stream(10, 90, -1, -1, 3, 1'b0, wr, sent, dn, gaps);
    chk("busy_start_writes", wr, 6);
    chk("busy_start_done", dn, 1'b1);
    @(negedge clk);
    chk("busy_start_err", err, 1'b1);
    @(posedge clk); #1;

    // start in the FIN cycle: rejected, no new load begins
    gen_words(3);
    build_exp(3);
    do_start(3, 1'b0);
    stream(0, 100, -1, -1, -1, 1'b1, wr, sent, dn, gaps);
    chk("fin_start_writes", wr, 3);
    @(negedge clk);
    chk("fin_start_err", err, 1'b1);
    chk("fin_start_busy", busy, 1'b0);
    @(posedge clk); #1;
    idle_probe();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
